// File: rtl/instr_decode_pipe.sv
// RV32I/RV64I instruction decoder with a single registered output stage,
// valid/ready flow control and saturating decode/illegal statistics counters.
module instr_decode_pipe #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ENABLE_M = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  pc_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       cls,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [2:0]       funct3,
  output logic [6:0]       funct7,
  output logic [XLEN-1:0]  imm,
  output logic             illegal,
  output logic [XLEN-1:0]  pc_out,
  output logic [CNT_W-1:0] dec_count,
  output logic [CNT_W-1:0] ill_count
);

  typedef enum logic [3:0] {
    ClsIllegal, ClsOp, ClsOpImm, ClsLoad, ClsStore, ClsBranch,
    ClsJal, ClsJalr, ClsLui, ClsAuipc, ClsSystem, ClsMiscMem
  } cls_e;

  localparam logic [6:0] OpcOp      = 7'b0110011;
  localparam logic [6:0] OpcOpImm   = 7'b0010011;
  localparam logic [6:0] OpcLoad    = 7'b0000011;
  localparam logic [6:0] OpcStore   = 7'b0100011;
  localparam logic [6:0] OpcBranch  = 7'b1100011;
  localparam logic [6:0] OpcJal     = 7'b1101111;
  localparam logic [6:0] OpcJalr    = 7'b1100111;
  localparam logic [6:0] OpcLui     = 7'b0110111;
  localparam logic [6:0] OpcAuipc   = 7'b0010111;
  localparam logic [6:0] OpcSystem  = 7'b1110011;
  localparam logic [6:0] OpcMiscMem = 7'b0001111;

  localparam bit Rv64 = (XLEN == 64);
  localparam bit HasM = (ENABLE_M != 0);

  logic [6:0]       opcode;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [31:0]      imm32;
  logic [XLEN+31:0] imm_wide;
  logic             bad;
  cls_e             cls_d;

  logic             valid_q;
  cls_e             cls_q;
  logic [4:0]       rd_q, rs1_q, rs2_q;
  logic [2:0]       funct3_q;
  logic [6:0]       funct7_q;
  logic [XLEN-1:0]  imm_q, pc_q;
  logic             illegal_q;
  logic [CNT_W-1:0] dec_q, ill_q;

  logic load, drain;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  // Decode class, legality and the 32-bit immediate of the incoming word
  always_comb begin
    cls_d = ClsIllegal;
    imm32 = '0;
    bad   = 1'b0;
    case (opcode)
      OpcOp: begin
        cls_d = ClsOp;
        bad   = !((f7 == 7'b0000000) ||
                  (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) ||
                  (f7 == 7'b0000001 && HasM));
      end
      OpcOpImm: begin
        cls_d = ClsOpImm;
        imm32 = {{20{instr[31]}}, instr[31:20]};
        // Shift-amount bit 5 only exists on RV64
        if (f3 == 3'b001) begin
          bad = (instr[31:26] != 6'b000000) || (!Rv64 && instr[25]);
        end else if (f3 == 3'b101) begin
          bad = !(instr[31:26] == 6'b000000 || instr[31:26] == 6'b010000) ||
                (!Rv64 && instr[25]);
        end
      end
      OpcLoad: begin
        cls_d = ClsLoad;
        imm32 = {{20{instr[31]}}, instr[31:20]};
        case (f3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: bad = 1'b0;
          3'b011, 3'b110:                         bad = !Rv64;
          default:                                bad = 1'b1;
        endcase
      end
      OpcStore: begin
        cls_d = ClsStore;
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        case (f3)
          3'b000, 3'b001, 3'b010: bad = 1'b0;
          3'b011:                 bad = !Rv64;
          default:                bad = 1'b1;
        endcase
      end
      OpcBranch: begin
        cls_d = ClsBranch;
        imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        bad   = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OpcJal: begin
        cls_d = ClsJal;
        imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OpcJalr: begin
        cls_d = ClsJalr;
        imm32 = {{20{instr[31]}}, instr[31:20]};
        bad   = (f3 != 3'b000);
      end
      OpcLui: begin
        cls_d = ClsLui;
        imm32 = {instr[31:12], 12'b0};
      end
      OpcAuipc: begin
        cls_d = ClsAuipc;
        imm32 = {instr[31:12], 12'b0};
      end
      OpcSystem: begin
        cls_d = ClsSystem;
        bad   = (instr != 32'h0000_0073) && (instr != 32'h0010_0073);
      end
      OpcMiscMem: begin
        cls_d = ClsMiscMem;
        bad   = (f3 != 3'b000);
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      cls_d = ClsIllegal;
      imm32 = '0;
    end
  end

  // Sign-extend the 32-bit immediate to the datapath width
  assign imm_wide = {{XLEN{imm32[31]}}, imm32};

  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready;
  assign drain    = valid_q && out_ready;

  // Output register stage and saturating statistics counters
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      cls_q     <= ClsIllegal;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      funct3_q  <= '0;
      funct7_q  <= '0;
      imm_q     <= '0;
      illegal_q <= 1'b0;
      pc_q      <= '0;
      dec_q     <= '0;
      ill_q     <= '0;
    end else begin
      if (load) begin
        valid_q   <= 1'b1;
        cls_q     <= cls_d;
        rd_q      <= instr[11:7];
        rs1_q     <= instr[19:15];
        rs2_q     <= instr[24:20];
        funct3_q  <= f3;
        funct7_q  <= f7;
        imm_q     <= imm_wide[XLEN-1:0];
        illegal_q <= bad;
        pc_q      <= pc_in;
      end else if (drain) begin
        valid_q <= 1'b0;
      end
      if (drain) begin
        if (dec_q != '1) dec_q <= dec_q + 1'b1;
        if (illegal_q && (ill_q != '1)) ill_q <= ill_q + 1'b1;
      end
    end
  end

  assign out_valid = valid_q;
  assign cls       = cls_q;
  assign rd        = rd_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign funct3    = funct3_q;
  assign funct7    = funct7_q;
  assign imm       = imm_q;
  assign illegal   = illegal_q;
  assign pc_out    = pc_q;
  assign dec_count = dec_q;
  assign ill_count = ill_q;

endmodule

// File: doc/instr_decode_pipe.md
# instr_decode_pipe

Registered RV32I/RV64I instruction decoder with a valid/ready handshake, sitting between instruction fetch and the register-read stage of the simulator core. It accepts one instruction word per handshake and produces structured fields: instruction class, register indices, funct fields, a fully sign-extended immediate and an illegal flag. It also keeps saturating counters of decoded and illegal instructions for trace and debug. It generalises the earlier combinational text disassembler in four ways: parametrised datapath width, complete opcode coverage, an optional M extension mode, and pipelined flow control.

## Interface
Parameters:
- XLEN, 32: datapath width. Legal values are 32 and 64. Sets the width of pc_in, pc_out and imm.
- ENABLE_M, 0: when 1, the M-extension encodings (OP with funct7 = 0000001) decode as legal.
- CNT_W, 16: width of the two statistics counters.

Ports:
- clk, input, 1: the single clock. All state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: instr and pc_in are valid.
- in_ready, output, 1: the block can accept an instruction this cycle.
- instr, input, 32: instruction word.
- pc_in, input, XLEN: PC of the instruction. Passed through unchanged.
- out_valid, output, 1: the output register holds a decoded instruction.
- out_ready, input, 1: the downstream stage accepts the output this cycle.
- cls, output, 4: instruction class. 0 ILLEGAL, 1 OP, 2 OP_IMM, 3 LOAD, 4 STORE, 5 BRANCH, 6 JAL, 7 JALR, 8 LUI, 9 AUIPC, 10 SYSTEM, 11 MISC_MEM.
- rd, rs1, rs2, output, 5 each: raw fields instr[11:7], instr[19:15], instr[24:20].
- funct3, output, 3: instr[14:12].
- funct7, output, 7: instr[31:25].
- imm, output, XLEN: sign-extended immediate.
- illegal, output, 1: the encoding is not supported.
- pc_out, output, XLEN: registered copy of pc_in.
- dec_count, output, CNT_W: number of instructions delivered downstream.
- ill_count, output, CNT_W: number of illegal instructions delivered downstream.

## Operation
Immediate formats, all sign-extended from bit 31 to XLEN:
- I-type (OP_IMM, LOAD, JALR): instr[31:20].
- S-type: {instr[31:25], instr[11:7]}.
- B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U-type: {instr[31:12], 12'b0}.
- J-type: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- OP, SYSTEM and MISC_MEM: imm = 0.

Legality rules. An instruction is illegal if any of the following holds:
- instr[1:0] != 11, or the opcode is not one of the 11 listed classes.
- OP: funct7 is not one of: 0000000; 0100000 with funct3 ∈ {000, 101}; 0000001 with ENABLE_M = 1.
- OP_IMM shifts:
  - funct3 = 001 requires instr[31:26] = 0.
  - funct3 = 101 requires instr[31:26] ∈ {000000, 010000}.
  - When XLEN = 32, instr[25] must also be 0.
- LOAD: funct3 ∉ {000, 001, 010, 100, 101}. When XLEN = 64, 011 and 110 are also legal.
- STORE: funct3 ∉ {000, 001, 010}. When XLEN = 64, 011 is also legal.
- BRANCH: funct3 ∈ {010, 011}.
- JALR: funct3 != 000.
- SYSTEM: instr is anything other than 0x00000073 (ecall) or 0x00100073 (ebreak).
- MISC_MEM: funct3 != 000.

On illegal: cls = 0, imm = 0, illegal = 1. rd, rs1, rs2, funct3 and funct7 still carry the raw fields.

Pipeline behaviour:
- One output register stage, no internal storage beyond it.
- in_ready = !out_valid || out_ready (combinational).
- Load on in_valid && in_ready: decode instr and register all outputs, set out_valid = 1.
- Downstream handshake (out_valid && out_ready) with no new load: out_valid clears to 0.
- Simultaneous downstream handshake and new load: the register reloads and out_valid stays 1. There is no bubble.
- While out_valid = 1 and out_ready = 0, all outputs hold stable.

Counters:
- On each downstream handshake, dec_count increments by 1. ill_count also increments by 1 if illegal = 1.
- Both saturate at 2^CNT_W − 1 and do not wrap.

## Timing
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 instruction per cycle when out_ready is held at 1.
- Reset values: out_valid = 0; cls, rd, rs1, rs2, funct3, funct7, imm, illegal, pc_out = 0; dec_count = 0; ill_count = 0. in_ready = 1 in the first cycle after reset.
- rst has priority over any handshake in the same cycle. An instruction held in the register during reset is dropped and not counted.
- Counters update on the same edge that completes the downstream handshake. Their new values are visible in the following cycle.

## Test plan
- add x3,x1,x2 (0x002081B3) -> cls = 1, rd = 3, rs1 = 1, rs2 = 2, funct3 = 0, funct7 = 0, imm = 0, illegal = 0, one cycle after the handshake.
- addi x1,x0,-1 (0xFFF00093) with XLEN = 64 -> cls = 2, imm = 0xFFFFFFFFFFFFFFFF.
- beq x1,x2,-4 (0xFE208EE3) -> cls = 5, imm = 0xFFFFFFFC. Then jal x1,+2048 (0x001000EF) -> cls = 6, rd = 1, imm = 0x00000800.
- mul x3,x1,x2 (0x022081B3):
  - ENABLE_M = 0 -> illegal = 1, cls = 0, ill_count = 1.
  - ENABLE_M = 1 -> cls = 1, illegal = 0.
- Backpressure:
  - Hold out_ready = 0 and offer 2 instructions back to back -> first accepted, in_ready = 0, outputs stable.
  - Raise out_ready -> second loads on the same edge the first leaves. dec_count = 2 after both drain.
- Reset and saturation:
  - Assert rst with out_valid = 1 -> next cycle out_valid = 0, counters = 0.
  - With CNT_W = 2, drain 5 instructions -> dec_count = 3.
